frame_encoder: RTL and testbench

Upstream stage of the frame decoder. It takes an address and a burst of 1–16 payload bytes, buffers the burst, then serialises it as one contiguous byte-per-clock frame: header, control, address, data, trailer. The output drives the decoder's `word_in` directly. The decoder samples every clock, so once a frame starts it is emitted without gaps.

---
 rtl/frame_encoder.sv | 158 +++++++++++++++
 tb/tb_frame_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_encoder.sv
// Buffers an address plus a 1-16 byte burst, then emits it as one gap-free frame:
// header, control, address, data, [checksum], trailer. Define FRAME_ENC_CHECKSUM_EN for checksum.
module frame_encoder #(
  parameter logic [7:0]  HDR   = 8'hC9,
  parameter logic [7:0]  TRL   = 8'h9C,
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr_in,
  input  logic [3:0] len_in,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] word_out,
  output logic       word_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StHdr  = 3'd2;
  localparam logic [2:0] StCtrl = 3'd3;
  localparam logic [2:0] StAddr = 3'd4;
  localparam logic [2:0] StData = 3'd5;
`ifdef FRAME_ENC_CHECKSUM_EN
  localparam logic [2:0] StCsum = 3'd6;
  localparam logic [3:0] CtrlHi = 4'h7;
`else
  localparam logic [3:0] CtrlHi = 4'h6;
`endif
  localparam logic [2:0] StTrl  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [3:0] n_m1_q, wcnt_q, rcnt_q;
  logic [7:0] addr_q;
  logic [7:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] ctrl_byte;
  logic       accept;
  logic       launch;
`ifdef FRAME_ENC_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign ctrl_byte  = {CtrlHi, n_m1_q};
  assign accept     = (state_q == StLoad) && data_valid;
  // Holding off while the trailer is still on the wire guarantees one idle cycle between frames.
  assign launch     = (state_q == StIdle) && start && !valid_q;

  assign data_ready = (state_q == StLoad);
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle) || valid_q;

  always_comb begin
    state_d = state_q;
    word_d  = 8'h00;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: if (launch) state_d = StLoad;
      StLoad: if (data_valid && (wcnt_q == n_m1_q)) state_d = StHdr;
      StHdr: begin
        state_d = StCtrl;
        word_d  = HDR;
        valid_d = 1'b1;
      end
      StCtrl: begin
        state_d = StAddr;
        word_d  = ctrl_byte;
        valid_d = 1'b1;
      end
      StAddr: begin
        state_d = StData;
        word_d  = addr_q;
        valid_d = 1'b1;
      end
      StData: begin
        word_d  = mem_q[rcnt_q];
        valid_d = 1'b1;
        if (rcnt_q == n_m1_q) begin
`ifdef FRAME_ENC_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StTrl;
`endif
        end
      end
`ifdef FRAME_ENC_CHECKSUM_EN
      StCsum: begin
        state_d = StTrl;
        word_d  = csum_q;
        valid_d = 1'b1;
      end
`endif
      StTrl: begin
        state_d = StIdle;
        word_d  = TRL;
        valid_d = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      n_m1_q  <= 4'd0;
      addr_q  <= 8'h00;
      wcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
      word_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (launch) begin
        addr_q <= addr_in;
        n_m1_q <= len_in;
        wcnt_q <= 4'd0;
        rcnt_q <= 4'd0;
      end
      // Both counters wrap 15->0 on the last beat of a 16-byte burst.
      if (accept) wcnt_q <= wcnt_q + 4'd1;
      if (state_q == StData) rcnt_q <= rcnt_q + 4'd1;
    end
  end

`ifdef FRAME_ENC_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= 8'h00;
    end else begin
      case (state_q)
        StHdr:   csum_q <= ctrl_byte;
        StAddr:  csum_q <= csum_q ^ addr_q;
        StData:  csum_q <= csum_q ^ mem_q[rcnt_q];
        default: csum_q <= csum_q;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (accept) mem_q[wcnt_q] <= data_in;
  end

endmodule

// File: tb/tb_frame_encoder.sv
// Self-checking bench for frame_encoder: directed and random frames checked against a frame model.
module tb_frame_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr_in = 8'h00;
  logic [3:0] len_in = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [7:0] word_out;
  logic       word_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int acc_total = 0;
  logic [7:0] pl[$];
  logic [7:0] exp_q[$];

  frame_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr_in    (addr_in),
    .len_in     (len_in),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (data_valid && data_ready) acc_total <= acc_total + 1;

  // Expected frame straight from the byte-layout rules.
  task automatic build_expected(input logic [7:0] a);
    logic [7:0] ctrl;
    logic [7:0] x;
    exp_q = {};
`ifdef FRAME_ENC_CHECKSUM_EN
    ctrl = 8'h70 | 8'(pl.size() - 1);
`else
    ctrl = 8'h60 | 8'(pl.size() - 1);
`endif
    exp_q.push_back(8'hC9);
    exp_q.push_back(ctrl);
    exp_q.push_back(a);
    x = ctrl ^ a;
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      x = x ^ pl[i];
    end
`ifdef FRAME_ENC_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    exp_q.push_back(8'h9C);
  endtask

  // gaps<0: random 0..2 idle cycles between bytes; poke: assert start while busy.
  task automatic run_frame(input logic [7:0] a, input int gaps, input bit poke, input string tag);
    int n;
    int acc0;
    n = pl.size();
    build_expected(a);
    start = 1'b1;
    addr_in = a;
    len_in = 4'(n - 1);
    @(negedge clk);
    start = 1'b0;
    addr_in = 8'($urandom);
    acc0 = acc_total;
    for (int i = 0; i < n; i++) begin
      int ng;
      ng = (i == 0) ? 0 : ((gaps < 0) ? int'($urandom_range(0, 2)) : gaps);
      for (int g = 0; g < ng; g++) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        @(negedge clk);
      end
      data_valid = 1'b1;
      data_in = pl[i];
      checks++;
      if (data_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_load byte %0d: got %b want 1", tag, i, data_ready);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    data_in = 8'($urandom);
    checks++;
    if (acc_total - acc0 != n) begin
      errors++;
      $display("FAIL %s accept_count: got %0d want %0d", tag, acc_total - acc0, n);
    end
    checks++;
    if ({data_ready, word_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL %s after_load ready/valid/busy: got %b want 001", tag,
               {data_ready, word_valid, busy});
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      checks++;
      if (word_out !== exp_q[j] || word_valid !== 1'b1 || busy !== 1'b1 ||
          done !== (j == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL %s byte %0d: got word=%h valid=%b busy=%b done=%b want word=%h valid=1 busy=1 done=%b",
                 tag, j, word_out, word_valid, busy, done, exp_q[j], (j == exp_q.size() - 1));
      end
      if (poke && (j == 1 || j == exp_q.size() - 1)) begin
        start = 1'b1;
        addr_in = ~a;
        len_in = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({word_out, word_valid, busy, done, data_ready} !== 12'h000) begin
      errors++;
      $display("FAIL %s post_frame: got word=%h valid=%b busy=%b done=%b ready=%b want all 0",
               tag, word_out, word_valid, busy, done, data_ready);
    end
    if (poke) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || data_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s start_ignored: got busy=%b ready=%b want 0 0", tag, busy, data_ready);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({word_out, word_valid, busy, done, data_ready} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got word=%h valid=%b busy=%b done=%b ready=%b want all 0",
               word_out, word_valid, busy, done, data_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: got busy=%b ready=%b want 0 0", busy, data_ready);
    end
  endtask

  task automatic test_single();
    pl = '{8'h61};
    run_frame(8'h60, 0, 1'b0, "single");
  endtask

  task automatic test_two();
    pl = '{8'h02, 8'h10};
    run_frame(8'h88, 0, 1'b0, "two");
  endtask

  task automatic test_full_burst();
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(i));
    run_frame(8'h5A, 0, 1'b0, "full");
  endtask

  task automatic test_gapped();
    pl = '{8'hA5, 8'h3C};
    run_frame(8'h42, 2, 1'b0, "gapped");
  endtask

  task automatic test_start_while_busy();
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h77, 0, 1'b1, "busy_start");
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    addr_in = 8'h88;
    len_in = 4'd1;
    @(negedge clk);
    start = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h02;
    @(negedge clk);
    data_in = 8'h10;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (word_out !== 8'h88 || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_addr_phase: got word=%h valid=%b want 88 1", word_out, word_valid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({word_out, word_valid, busy, done, data_ready} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_async: got word=%h valid=%b busy=%b done=%b ready=%b want all 0",
               word_out, word_valid, busy, done, data_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pl = '{8'h61};
    run_frame(8'h60, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int n;
      n = int'($urandom_range(1, 16));
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame(8'($urandom), -1, ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_full_burst();
    test_gapped();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
